// File: rtl/traffic_pkg.sv
// Shared light codes and phase encoding for the intersection scheduler.
// Latency: n/a (types only). Backpressure: n/a.
// Phase encoding is exported on the debug port, so values are fixed.
package traffic_pkg;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

    typedef enum logic [2:0] {
        INIT_RED  = 3'd0,
        NS_G      = 3'd1,
        NS_Y      = 3'd2,
        RED_TO_EW = 3'd3,
        EW_G      = 3'd4,
        EW_Y      = 3'd5,
        RED_TO_NS = 3'd6
    } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Tick-qualified phase counter with clear, saturation and limit compares.
// Latency: compares reflect the registered count (valid the cycle after update).
// Backpressure: none; clear wins over a same-cycle tick.
module phase_timer #(
    parameter int CW        = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clr,
    output logic min_done,
    output logic max_done,
    output logic yel_done,
    output logic red_done
);

    localparam logic [CW-1:0] MIN_LIM = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_LIM = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YEL_LIM = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] RED_LIM = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick && (cnt != CNT_SAT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign min_done = (cnt >= MIN_LIM);
    assign max_done = (cnt >= MAX_LIM);
    assign yel_done = (cnt == YEL_LIM);
    assign red_done = (cnt == RED_LIM);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated NS/EW phase scheduler with pedestrian service and emergency preempt.
// Latency: decisions taken on tick cycles; outputs decode registered state only.
// Backpressure: none; requests are latched until their approach is served.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CW        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_ns,
    input  logic       ped_ew,
    input  logic       emerg,
    input  logic       emerg_dir,
    output logic [1:0] NS,
    output logic [1:0] EW,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase
);

    phase_t state;
    phase_t state_n;

    logic min_done, max_done, yel_done, red_done;
    logic req_ns, req_ew, ped_ns_l, ped_ew_l, walk_ns_f, walk_ew_f;
    logic opp_ns, opp_ew;
    logic enter_ns, enter_ew, exit_ns, exit_ew;

    phase_timer #(
        .CW       (CW),
        .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .clr     (state_n != state),
        .min_done(min_done),
        .max_done(max_done),
        .yel_done(yel_done),
        .red_done(red_done)
    );

    assign opp_ns = req_ew | ped_ew_l;
    assign opp_ew = req_ns | ped_ns_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT_RED;
        end else begin
            state <= state_n;
        end
    end

    // A preempt toward the green approach holds it regardless of demand or max green.
    always_comb begin
        state_n = state;
        if (tick) begin
            case (state)
                INIT_RED:  if (red_done) state_n = NS_G;
                NS_G: begin
                    if (emerg) begin
                        if (emerg_dir) state_n = NS_Y;
                    end else if (opp_ns && (max_done || (min_done && !car_ns))) begin
                        state_n = NS_Y;
                    end
                end
                NS_Y:      if (yel_done) state_n = RED_TO_EW;
                RED_TO_EW: if (red_done) state_n = EW_G;
                EW_G: begin
                    if (emerg) begin
                        if (!emerg_dir) state_n = EW_Y;
                    end else if (opp_ew && (max_done || (min_done && !car_ew))) begin
                        state_n = EW_Y;
                    end
                end
                EW_Y:      if (yel_done) state_n = RED_TO_NS;
                RED_TO_NS: if (red_done) state_n = NS_G;
                default:   state_n = INIT_RED;
            endcase
        end
    end

    assign enter_ns = (state_n == NS_G) && (state != NS_G);
    assign enter_ew = (state_n == EW_G) && (state != EW_G);
    assign exit_ns  = (state == NS_G) && (state_n != NS_G);
    assign exit_ew  = (state == EW_G) && (state_n != EW_G);

    // Entry clears win over same-cycle sets; a press during green re-arms for next service.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ns    <= 1'b0;
            req_ew    <= 1'b0;
            ped_ns_l  <= 1'b0;
            ped_ew_l  <= 1'b0;
            walk_ns_f <= 1'b0;
            walk_ew_f <= 1'b0;
        end else begin
            if (enter_ns) begin
                req_ns <= 1'b0;
            end else if ((state != NS_G) && (car_ns || ped_ns)) begin
                req_ns <= 1'b1;
            end
            if (enter_ew) begin
                req_ew <= 1'b0;
            end else if ((state != EW_G) && (car_ew || ped_ew)) begin
                req_ew <= 1'b1;
            end
            if (enter_ns) begin
                ped_ns_l <= 1'b0;
            end else if (ped_ns) begin
                ped_ns_l <= 1'b1;
            end
            if (enter_ew) begin
                ped_ew_l <= 1'b0;
            end else if (ped_ew) begin
                ped_ew_l <= 1'b1;
            end
            if (enter_ns) begin
                walk_ns_f <= ped_ns_l;
            end else if (exit_ns) begin
                walk_ns_f <= 1'b0;
            end
            if (enter_ew) begin
                walk_ew_f <= ped_ew_l;
            end else if (exit_ew) begin
                walk_ew_f <= 1'b0;
            end
        end
    end

    always_comb begin
        NS = LT_RED;
        EW = LT_RED;
        case (state)
            NS_G:    NS = LT_GRN;
            NS_Y:    NS = LT_YEL;
            EW_G:    EW = LT_GRN;
            EW_Y:    EW = LT_YEL;
            default: ;
        endcase
        walk_ns = walk_ns_f && (state == NS_G);
        walk_ew = walk_ew_f && (state == EW_G);
        phase   = state;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboarded directed bench: stimulus queues the expected post-edge outputs,
// a monitor pops and compares them one cycle at a time.
module tb_traffic_phase_scheduler;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

    typedef struct {
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wn;
        logic       we;
        logic [2:0] ph;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, tick, car_ns, car_ew, ped_ns, ped_ew, emerg, emerg_dir;
    logic [1:0] NS, EW;
    logic       walk_ns, walk_ew;
    logic [2:0] phase;

    exp_t sb[$];
    int   step   = 0;
    int   checks = 0;
    int   fails  = 0;

    traffic_phase_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .car_ns   (car_ns),
        .car_ew   (car_ew),
        .ped_ns   (ped_ns),
        .ped_ew   (ped_ew),
        .emerg    (emerg),
        .emerg_dir(emerg_dir),
        .NS       (NS),
        .EW       (EW),
        .walk_ns  (walk_ns),
        .walk_ew  (walk_ew),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // Queue the outputs expected after each of the next n edges, inputs held.
    task automatic cyc(input int n, input logic [1:0] ens, input logic [1:0] eew,
                       input logic ewn, input logic ewe, input logic [2:0] eph);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ns  = ens;
            e.ew  = eew;
            e.wn  = ewn;
            e.we  = ewe;
            e.ph  = eph;
            e.idx = step;
            step++;
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        car_ns = 0; car_ew = 0; ped_ns = 0; ped_ew = 0;
        emerg = 0; emerg_dir = 0; tick = 1; reset = 1;
        cyc(1, R, R, 0, 0, 3'd0);
        reset = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (NS !== e.ns || EW !== e.ew || walk_ns !== e.wn ||
                    walk_ew !== e.we || phase !== e.ph) begin
                    fails++;
                    $display("FAIL step%0d: got NS=%b EW=%b walk_ns=%b walk_ew=%b phase=%0d, want NS=%b EW=%b walk_ns=%b walk_ew=%b phase=%0d",
                             e.idx, NS, EW, walk_ns, walk_ew, phase,
                             e.ns, e.ew, e.wn, e.we, e.ph);
                end
                checks++;
                if (NS !== R && EW !== R) begin
                    fails++;
                    $display("FAIL step%0d conflict: got NS=%b EW=%b, want at least one red",
                             e.idx, NS, EW);
                end
            end
        end
    end

    initial begin : stimulus
        car_ns = 0; car_ew = 0; ped_ns = 0; ped_ew = 0;
        emerg = 0; emerg_dir = 0; tick = 1; reset = 1;
        @(negedge clk);

        // 1: idle rest on NS green
        do_reset();
        cyc(22, G, R, 0, 0, 3'd1);

        // 2: EW car pulse -> min green, yellow, all-red, EW green rests
        do_reset();
        cyc(2, G, R, 0, 0, 3'd1);
        car_ew = 1;
        cyc(1, G, R, 0, 0, 3'd1);
        car_ew = 0;
        cyc(1, G, R, 0, 0, 3'd1);
        cyc(2, Y, R, 0, 0, 3'd2);
        cyc(1, R, R, 0, 0, 3'd3);
        cyc(5, R, G, 0, 0, 3'd4);

        // 3: NS car held -> max green of 8 ticks, then EW yields after min green
        do_reset();
        car_ns = 1;
        cyc(2, G, R, 0, 0, 3'd1);
        car_ew = 1;
        cyc(1, G, R, 0, 0, 3'd1);
        car_ew = 0;
        cyc(5, G, R, 0, 0, 3'd1);
        cyc(2, Y, R, 0, 0, 3'd2);
        cyc(1, R, R, 0, 0, 3'd3);
        cyc(4, R, G, 0, 0, 3'd4);
        cyc(1, R, Y, 0, 0, 3'd5);
        car_ns = 0;

        // 4: off-tick EW ped press, walk through EW green, re-press served next time
        do_reset();
        cyc(2, G, R, 0, 0, 3'd1);
        tick = 0; ped_ew = 1;
        cyc(1, G, R, 0, 0, 3'd1);
        tick = 1; ped_ew = 0;
        cyc(2, G, R, 0, 0, 3'd1);
        cyc(2, Y, R, 0, 0, 3'd2);
        cyc(1, R, R, 0, 0, 3'd3);
        cyc(1, R, G, 0, 1, 3'd4);
        ped_ew = 1;
        cyc(1, R, G, 0, 1, 3'd4);
        ped_ew = 0;
        cyc(1, R, G, 0, 1, 3'd4);
        car_ns = 1;
        cyc(1, R, G, 0, 1, 3'd4);
        car_ns = 0;
        cyc(2, R, Y, 0, 0, 3'd5);
        cyc(1, R, R, 0, 0, 3'd6);
        cyc(4, G, R, 0, 0, 3'd1);
        cyc(2, Y, R, 0, 0, 3'd2);
        cyc(1, R, R, 0, 0, 3'd3);
        cyc(3, R, G, 0, 1, 3'd4);

        // 5: EW preempt cuts NS min green, holds EW against NS demand
        do_reset();
        cyc(2, G, R, 0, 0, 3'd1);
        emerg = 1; emerg_dir = 1; car_ns = 1;
        cyc(2, Y, R, 0, 0, 3'd2);
        cyc(1, R, R, 0, 0, 3'd3);
        cyc(30, R, G, 0, 0, 3'd4);
        emerg = 0;
        cyc(2, R, Y, 0, 0, 3'd5);
        cyc(1, R, R, 0, 0, 3'd6);
        cyc(4, G, R, 0, 0, 3'd1);
        car_ns = 0; emerg_dir = 0;

        // 6: reset during EW yellow clears state and latches
        do_reset();
        cyc(2, G, R, 0, 0, 3'd1);
        car_ew = 1;
        cyc(1, G, R, 0, 0, 3'd1);
        car_ew = 0;
        cyc(1, G, R, 0, 0, 3'd1);
        cyc(2, Y, R, 0, 0, 3'd2);
        cyc(1, R, R, 0, 0, 3'd3);
        cyc(1, R, G, 0, 0, 3'd4);
        car_ns = 1; ped_ns = 1;
        cyc(1, R, G, 0, 0, 3'd4);
        car_ns = 0; ped_ns = 0;
        cyc(2, R, G, 0, 0, 3'd4);
        cyc(1, R, Y, 0, 0, 3'd5);
        reset = 1;
        cyc(1, R, R, 0, 0, 3'd0);
        reset = 0;
        cyc(8, G, R, 0, 0, 3'd1);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
